// File: rtl/int_req_arbiter_if.sv
// Signal bundle between the interrupt controller/pipeline and int_req_arbiter.
// The master drives requests and controls; the slave returns break and status.
interface int_req_arbiter_if;
    logic [2:0] in_IRQ;
    logic [2:0] in_MASK;
    logic       in_NIE;
    logic       in_HOLD;
    logic [3:0] in_IG;
    logic       out_BK;
    logic [1:0] out_code;
    logic [2:0] out_pending;
    logic [2:0] out_inservice;

    modport master (
        output in_IRQ, in_MASK, in_NIE, in_HOLD, in_IG,
        input  out_BK, out_code, out_pending, out_inservice
    );

    modport slave (
        input  in_IRQ, in_MASK, in_NIE, in_HOLD, in_IG,
        output out_BK, out_code, out_pending, out_inservice
    );
endinterface

// File: rtl/int_req_arbiter.sv
// Three-source fixed-priority interrupt arbiter: synchronises raw request lines,
// latches rising edges as pending, and issues one-cycle breaks with nesting control.
module int_req_arbiter (
    input  logic             in_CLK,
    input  logic             in_RST,
    int_req_arbiter_if.slave bus
);

    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] prev_q, prev_d;
    logic [1:0] settle_q, settle_d;
    logic [2:0] pending_q, pending_d;
    logic [2:0] inservice_q, inservice_d;
    logic [1:0] lock_q, lock_d;
    logic       bk_q, bk_d;
    logic [1:0] code_q, code_d;

    logic [2:0] masked_s;
    logic [1:0] cand_code_s;
    logic [2:0] cand_oh_s;
    logic [1:0] level_s;
    logic       take_s;
    logic [2:0] take_oh_s;
    logic       settled_s;
    logic [2:0] edge_s;
    logic       unused_ig_s;

    assign unused_ig_s = bus.in_IG[3];

    // Candidate selection, in-service level and take decision.
    always_comb begin
        masked_s    = pending_q & bus.in_MASK;
        cand_code_s = 2'd0;
        cand_oh_s   = 3'b000;
        level_s     = 2'd0;
        if (masked_s[2]) begin
            cand_code_s = 2'd3;
            cand_oh_s   = 3'b100;
        end else if (masked_s[1]) begin
            cand_code_s = 2'd2;
            cand_oh_s   = 3'b010;
        end else if (masked_s[0]) begin
            cand_code_s = 2'd1;
            cand_oh_s   = 3'b001;
        end else begin
            cand_code_s = 2'd0;
            cand_oh_s   = 3'b000;
        end
        if (inservice_q[2]) begin
            level_s = 2'd3;
        end else if (inservice_q[1]) begin
            level_s = 2'd2;
        end else if (inservice_q[0]) begin
            level_s = 2'd1;
        end else begin
            level_s = 2'd0;
        end
        take_s = bus.in_NIE && !bus.in_HOLD && (lock_q == 2'd0) && !bk_q &&
                 (cand_code_s != 2'd0) && (cand_code_s > level_s);
        if (take_s) begin
            take_oh_s = cand_oh_s;
        end else begin
            take_oh_s = 3'b000;
        end
    end

    // Next-state logic for synchroniser, edge detect, pending/in-service and break.
    always_comb begin
        settled_s = (settle_q == 2'd2);
        sync1_d   = bus.in_IRQ;
        sync2_d   = sync1_q;
        // Until the chain has refilled after reset, prev loads alongside sync2 so a
        // line held high through reset never looks like a fresh edge.
        if (settled_s) begin
            settle_d = settle_q;
            prev_d   = sync2_q;
        end else begin
            settle_d = settle_q + 2'd1;
            prev_d   = sync1_q;
        end
        edge_s      = sync2_q & ~prev_q & {3{settled_s}};
        pending_d   = (pending_q & ~take_oh_s) | edge_s;
        inservice_d = (inservice_q & ~bus.in_IG[2:0]) | take_oh_s;
        bk_d        = take_s;
        if (take_s) begin
            code_d = cand_code_s;
            lock_d = 2'd2;
        end else if (lock_q != 2'd0) begin
            code_d = code_q;
            lock_d = lock_q - 2'd1;
        end else begin
            code_d = code_q;
            lock_d = 2'd0;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            sync1_q     <= 3'b000;
            sync2_q     <= 3'b000;
            prev_q      <= 3'b000;
            settle_q    <= 2'd0;
            pending_q   <= 3'b000;
            inservice_q <= 3'b000;
            lock_q      <= 2'd0;
            bk_q        <= 1'b0;
            code_q      <= 2'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            settle_q    <= settle_d;
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
            lock_q      <= lock_d;
            bk_q        <= bk_d;
            code_q      <= code_d;
        end
    end

    assign bus.out_BK        = bk_q;
    assign bus.out_code      = code_q;
    assign bus.out_pending   = pending_q;
    assign bus.out_inservice = inservice_q;

endmodule

// File: tb/tb_int_req_arbiter.sv
// Directed self-checking bench for int_req_arbiter; each task covers one scenario
// with hand-computed expectations sampled 1 time unit after the rising edge.
module tb_int_req_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int_req_arbiter_if bus_if ();

    int_req_arbiter dut (
        .in_CLK (clk),
        .in_RST (rst),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL reset_bk got %b want 0", bus_if.out_BK); end
        checks++; if (bus_if.out_code !== 2'b00) begin errors++; $display("FAIL reset_code got %b want 00", bus_if.out_code); end
        checks++; if (bus_if.out_pending !== 3'b000) begin errors++; $display("FAIL reset_pending got %b want 000", bus_if.out_pending); end
        checks++; if (bus_if.out_inservice !== 3'b000) begin errors++; $display("FAIL reset_inservice got %b want 000", bus_if.out_inservice); end
        tick(2);
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_latency();
        bus_if.in_IRQ = 3'b001;
        tick(2);
        checks++; if (bus_if.out_pending !== 3'b000) begin errors++; $display("FAIL lat_pend_e2 got %b want 000", bus_if.out_pending); end
        tick(1);
        checks++; if (bus_if.out_pending !== 3'b001) begin errors++; $display("FAIL lat_pend_e3 got %b want 001", bus_if.out_pending); end
        checks++; if (bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL lat_bk_e3 got %b want 0", bus_if.out_BK); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b1) begin errors++; $display("FAIL lat_bk_e4 got %b want 1", bus_if.out_BK); end
        checks++; if (bus_if.out_code !== 2'b01) begin errors++; $display("FAIL lat_code got %b want 01", bus_if.out_code); end
        checks++; if (bus_if.out_pending !== 3'b000) begin errors++; $display("FAIL lat_pend_e4 got %b want 000", bus_if.out_pending); end
        checks++; if (bus_if.out_inservice !== 3'b001) begin errors++; $display("FAIL lat_insv got %b want 001", bus_if.out_inservice); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL lat_bk_e5 got %b want 0", bus_if.out_BK); end
        checks++; if (bus_if.out_code !== 2'b01) begin errors++; $display("FAIL lat_code_hold got %b want 01", bus_if.out_code); end
        bus_if.in_IRQ = 3'b000;
        bus_if.in_IG  = 4'b1000;
        tick(1);
        checks++; if (bus_if.out_inservice !== 3'b001) begin errors++; $display("FAIL ig_bit3_ignored got %b want 001", bus_if.out_inservice); end
        bus_if.in_IG = 4'b0001;
        tick(1);
        bus_if.in_IG = 4'b0000;
        checks++; if (bus_if.out_inservice !== 3'b000) begin errors++; $display("FAIL lat_ig_clear got %b want 000", bus_if.out_inservice); end
        tick(3);
    endtask

    task automatic test_priority();
        bus_if.in_IRQ = 3'b011;
        tick(3);
        checks++; if (bus_if.out_pending !== 3'b011) begin errors++; $display("FAIL pri_pend got %b want 011", bus_if.out_pending); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_code !== 2'b10) begin errors++; $display("FAIL pri_first got bk=%b code=%b want bk=1 code=10", bus_if.out_BK, bus_if.out_code); end
        checks++; if (bus_if.out_pending !== 3'b001 || bus_if.out_inservice !== 3'b010) begin errors++; $display("FAIL pri_state got pend=%b insv=%b want 001/010", bus_if.out_pending, bus_if.out_inservice); end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++; if (bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL pri_wait got bk=%b want 0 cycle %0d", bus_if.out_BK, i); end
        end
        bus_if.in_IG = 4'b0010;
        tick(1);
        bus_if.in_IG = 4'b0000;
        checks++; if (bus_if.out_inservice !== 3'b000 || bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL pri_ig got insv=%b bk=%b want 000/0", bus_if.out_inservice, bus_if.out_BK); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_code !== 2'b01) begin errors++; $display("FAIL pri_second got bk=%b code=%b want bk=1 code=01", bus_if.out_BK, bus_if.out_code); end
        bus_if.in_IRQ = 3'b000;
        bus_if.in_IG  = 4'b0001;
        tick(1);
        bus_if.in_IG = 4'b0000;
        tick(3);
    endtask

    task automatic test_nesting();
        bus_if.in_IRQ = 3'b001;
        tick(4);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_inservice !== 3'b001) begin errors++; $display("FAIL nest_base got bk=%b insv=%b want 1/001", bus_if.out_BK, bus_if.out_inservice); end
        bus_if.in_IRQ = 3'b101;
        tick(4);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_code !== 2'b11) begin errors++; $display("FAIL nest_take got bk=%b code=%b want 1/11", bus_if.out_BK, bus_if.out_code); end
        checks++; if (bus_if.out_inservice !== 3'b101) begin errors++; $display("FAIL nest_insv got %b want 101", bus_if.out_inservice); end
        bus_if.in_IRQ = 3'b111;
        tick(3);
        checks++; if (bus_if.out_pending !== 3'b010) begin errors++; $display("FAIL nest_pend2 got %b want 010", bus_if.out_pending); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++; if (bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL nest_block got bk=%b want 0 cycle %0d", bus_if.out_BK, i); end
        end
        bus_if.in_IG = 4'b0100;
        tick(1);
        bus_if.in_IG = 4'b0000;
        checks++; if (bus_if.out_inservice !== 3'b001 || bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL nest_ig got insv=%b bk=%b want 001/0", bus_if.out_inservice, bus_if.out_BK); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_code !== 2'b10 || bus_if.out_inservice !== 3'b011) begin errors++; $display("FAIL nest_src2 got bk=%b code=%b insv=%b want 1/10/011", bus_if.out_BK, bus_if.out_code, bus_if.out_inservice); end
        bus_if.in_IRQ = 3'b000;
        bus_if.in_IG  = 4'b0010;
        tick(1);
        bus_if.in_IG = 4'b0001;
        tick(1);
        bus_if.in_IG = 4'b0000;
        checks++; if (bus_if.out_inservice !== 3'b000) begin errors++; $display("FAIL nest_cleanup got %b want 000", bus_if.out_inservice); end
        tick(3);
    endtask

    task automatic test_hold_mask();
        bus_if.in_HOLD = 1'b1;
        bus_if.in_IRQ  = 3'b100;
        tick(3);
        checks++; if (bus_if.out_pending !== 3'b100) begin errors++; $display("FAIL hold_pend got %b want 100", bus_if.out_pending); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++; if (bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL hold_block got bk=%b want 0 cycle %0d", bus_if.out_BK, i); end
        end
        bus_if.in_HOLD = 1'b0;
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_code !== 2'b11) begin errors++; $display("FAIL hold_release got bk=%b code=%b want 1/11", bus_if.out_BK, bus_if.out_code); end
        bus_if.in_IRQ = 3'b000;
        bus_if.in_IG  = 4'b0100;
        tick(1);
        bus_if.in_IG = 4'b0000;
        tick(3);
        bus_if.in_MASK = 3'b011;
        bus_if.in_IRQ  = 3'b100;
        tick(8);
        checks++; if (bus_if.out_pending !== 3'b100 || bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL mask_retain got pend=%b bk=%b want 100/0", bus_if.out_pending, bus_if.out_BK); end
        bus_if.in_MASK = 3'b111;
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_code !== 2'b11 || bus_if.out_pending !== 3'b000) begin errors++; $display("FAIL mask_restore got bk=%b code=%b pend=%b want 1/11/000", bus_if.out_BK, bus_if.out_code, bus_if.out_pending); end
        bus_if.in_IRQ = 3'b000;
        bus_if.in_IG  = 4'b0100;
        tick(1);
        bus_if.in_IG = 4'b0000;
        tick(3);
    endtask

    task automatic test_lockout();
        bus_if.in_IRQ = 3'b001;
        tick(1);
        bus_if.in_IRQ = 3'b101;
        tick(3);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_code !== 2'b01 || bus_if.out_pending !== 3'b100) begin errors++; $display("FAIL lock_take got bk=%b code=%b pend=%b want 1/01/100", bus_if.out_BK, bus_if.out_code, bus_if.out_pending); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL lock_n1 got bk=%b want 0", bus_if.out_BK); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b0 || bus_if.out_pending !== 3'b100) begin errors++; $display("FAIL lock_n2 got bk=%b pend=%b want 0/100", bus_if.out_BK, bus_if.out_pending); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_code !== 2'b11 || bus_if.out_inservice !== 3'b101) begin errors++; $display("FAIL lock_n3 got bk=%b code=%b insv=%b want 1/11/101", bus_if.out_BK, bus_if.out_code, bus_if.out_inservice); end
        bus_if.in_IRQ = 3'b000;
        bus_if.in_IG  = 4'b0100;
        tick(1);
        bus_if.in_IG = 4'b0001;
        tick(1);
        bus_if.in_IG = 4'b0000;
        tick(3);
    endtask

    task automatic test_simultaneous();
        bus_if.in_HOLD = 1'b1;
        bus_if.in_IRQ  = 3'b001;
        tick(3);
        bus_if.in_IRQ = 3'b000;
        tick(3);
        checks++; if (bus_if.out_pending !== 3'b001) begin errors++; $display("FAIL sim_setup got %b want 001", bus_if.out_pending); end
        bus_if.in_IRQ = 3'b001;
        tick(2);
        bus_if.in_HOLD = 1'b0;
        bus_if.in_IG   = 4'b0001;
        tick(1);
        bus_if.in_IG = 4'b0000;
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_code !== 2'b01) begin errors++; $display("FAIL sim_take got bk=%b code=%b want 1/01", bus_if.out_BK, bus_if.out_code); end
        checks++; if (bus_if.out_pending !== 3'b001) begin errors++; $display("FAIL sim_pend_keep got %b want 001", bus_if.out_pending); end
        checks++; if (bus_if.out_inservice !== 3'b001) begin errors++; $display("FAIL sim_insv_keep got %b want 001", bus_if.out_inservice); end
        bus_if.in_IG = 4'b0001;
        tick(1);
        bus_if.in_IG = 4'b0000;
        checks++; if (bus_if.out_inservice !== 3'b000 || bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL sim_ig got insv=%b bk=%b want 000/0", bus_if.out_inservice, bus_if.out_BK); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b0) begin errors++; $display("FAIL sim_lock got bk=%b want 0", bus_if.out_BK); end
        tick(1);
        checks++; if (bus_if.out_BK !== 1'b1 || bus_if.out_pending !== 3'b000) begin errors++; $display("FAIL sim_retake got bk=%b pend=%b want 1/000", bus_if.out_BK, bus_if.out_pending); end
        bus_if.in_IRQ = 3'b000;
        bus_if.in_IG  = 4'b0001;
        tick(1);
        bus_if.in_IG = 4'b0000;
        tick(3);
    endtask

    task automatic test_reset_mid();
        bus_if.in_IRQ = 3'b001;
        tick(4);
        bus_if.in_HOLD = 1'b1;
        bus_if.in_IRQ  = 3'b111;
        tick(4);
        checks++; if (bus_if.out_pending !== 3'b110 || bus_if.out_inservice !== 3'b001) begin errors++; $display("FAIL rstmid_setup got pend=%b insv=%b want 110/001", bus_if.out_pending, bus_if.out_inservice); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus_if.out_pending !== 3'b000 || bus_if.out_inservice !== 3'b000) begin errors++; $display("FAIL rstmid_state got pend=%b insv=%b want 000/000", bus_if.out_pending, bus_if.out_inservice); end
        checks++; if (bus_if.out_BK !== 1'b0 || bus_if.out_code !== 2'b00) begin errors++; $display("FAIL rstmid_out got bk=%b code=%b want 0/00", bus_if.out_BK, bus_if.out_code); end
        tick(2);
        bus_if.in_HOLD = 1'b0;
        #3;
        rst = 1'b0;
        tick(8);
        checks++; if (bus_if.out_pending !== 3'b000 || bus_if.out_BK !== 1'b0 || bus_if.out_inservice !== 3'b000) begin errors++; $display("FAIL rstmid_noedge got pend=%b bk=%b insv=%b want 000/0/000", bus_if.out_pending, bus_if.out_BK, bus_if.out_inservice); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        bus_if.in_IRQ  = 3'b000;
        bus_if.in_MASK = 3'b111;
        bus_if.in_NIE  = 1'b1;
        bus_if.in_HOLD = 1'b0;
        bus_if.in_IG   = 4'b0000;
        #2;
        test_reset();
        test_latency();
        test_priority();
        test_nesting();
        test_hold_mask();
        test_lockout();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_req_arbiter.md
INT_REQ_ARBITER -- requirements
Module: int_req_arbiter

Interface
REQ-001 in_CLK  input  1  system clock; all state updates on its rising edge.
REQ-002 in_RST  input  1  reset, asynchronous, active-high.
REQ-003 in_IRQ  input  3  raw asynchronous interrupt request lines; bit0 = source 1, bit1 = source 2, bit2 = source 3.
REQ-004 in_MASK  input  3  per-source enable, 1 = source may be taken; same bit order as in_IRQ.
REQ-005 in_NIE  input  1  global interrupt enable from the interrupt controller, 1 = interrupts may be taken.
REQ-006 in_HOLD  input  1  pipeline cannot accept a break this cycle, 1 = defer.
REQ-007 in_IG  input  4  one-hot end-of-service from the interrupt controller; bit0 = source 1, bit1 = source 2, bit2 = source 3; bit3 is unused.
REQ-008 out_BK  output  1  one-cycle break request to the interrupt controller.
REQ-009 out_code  output  2  code of the taken source (01/10/11), valid while out_BK=1 and held afterwards.
REQ-010 out_pending  output  3  latched, not-yet-taken requests.
REQ-011 out_inservice  output  3  sources taken and not yet returned.

Function
REQ-012 Each in_IRQ bit SHALL pass through a 2-flop synchronizer, followed by a registered previous-value flop for rising-edge detection.
REQ-013 A detected rising edge (synced=1, prev=0) SHALL set the matching pending bit at that clock edge.
REQ-014 Priority SHALL be fixed: source 3 (code 11) > source 2 (10) > source 1 (01).
REQ-015 Candidate SHALL be the highest-priority bit of out_pending & in_MASK.
REQ-016 The candidate is taken at a clock edge only when all of the following hold:
- in_NIE=1
- in_HOLD=0
- lockout counter = 0
- out_BK currently 0
- candidate priority is strictly higher than the highest out_inservice bit (or out_inservice = 0)
REQ-017 On take, at that edge:
- out_BK <= 1
- out_code <= candidate code
- candidate pending bit cleared
- candidate inservice bit set
- lockout counter <= 2
REQ-018 When no take occurs, out_BK SHALL be 0 (out_BK is never high for two consecutive cycles); out_code keeps its last value.
REQ-019 The lockout counter SHALL decrement by 1 per cycle while nonzero. This covers the one-cycle lag of in_NIE after a break.
REQ-020 in_IG bits 0..2 SHALL clear the matching inservice bit at the clock edge. in_IG bit 3 and in_IG = 0000 SHALL be ignored.
REQ-021 Simultaneous events at one edge:
- New edge for a source whose pending bit is being cleared by a take: pending SHALL remain 1.
- in_IG clear and a take for the same source: inservice SHALL remain 1.
- Clears and takes for different sources: both apply independently.
REQ-022 A masked pending bit SHALL be retained (not dropped) and becomes eligible when unmasked.
REQ-023 A pending request of lower or equal priority than an in-service source SHALL wait until that inservice bit clears.
REQ-024 Latency: in_IRQ rising before edge 1 with the block idle and eligible SHALL give pending=1 after edge 3 and out_BK=1 for the cycle after edge 4.

Reset
REQ-025 While in_RST=1, the following SHALL be 0 immediately (asynchronous): synchronizers, previous-value flops, out_pending, out_inservice, lockout counter, out_BK, out_code.
REQ-026 A request whose edge has not yet set its pending bit when in_RST asserts SHALL be lost.
REQ-027 A line still high after reset release SHALL NOT generate an edge (prev and sync reload together, so no 0->1 transition is seen).

Verification
REQ-028 Idle, in_NIE=1, in_MASK=111, in_IRQ=001 raised before edge 1 -> pending=001 after edge 3; out_BK=1, out_code=01 in the cycle after edge 4; then pending=000, inservice=001.
REQ-029 in_IRQ=011 rise together -> first out_BK with code 10; after in_IG=0010 and lockout expiry, second out_BK with code 01.
REQ-030 Source 1 in service, source 3 edge -> out_BK with code 11 (nesting), inservice=101. Source 2 edge meanwhile -> no out_BK until in_IG=0100 clears source 3.
REQ-031 Pending=100, in_HOLD=1 for 5 cycles -> out_BK stays 0. Cycle after in_HOLD falls -> out_BK=1, code=11. Same result with in_MASK[2]=0 then restored.
REQ-032 Take at edge N -> out_BK=0 at edges N+1 and N+2 even with in_NIE=1 and a new eligible higher-priority pending. Earliest next out_BK is at edge N+3.
REQ-033 in_RST pulsed mid-cycle with pending=110, inservice=001 -> all outputs 0 before the next edge. in_IRQ held at 111 after release -> no pending set.
